// File: rtl/cache_access_ctrl_if.sv
// Request, lookup, refill and response signals shared by the cache access
// controller (slave side) and its requesters, cache array and memory (master side).
interface cache_access_ctrl_if #(
    parameter int ADDR_W = 24,
    parameter int WAYS   = 4,
    parameter int CNT_W  = 32
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic              req_write0;
    logic              req_write1;

    logic              lk_valid;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_write;
    logic              lk_done;
    logic              lk_hit;
    logic [WAY_W-1:0]  lk_way;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;

    logic              fill_en;
    logic [WAY_W-1:0]  fill_way;

    logic [1:0]        resp_valid;
    logic              resp_hit;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_write0, req_write1,
               lk_done, lk_hit, lk_way, mem_req_ready, mem_resp_valid,
        output req_ready, lk_valid, lk_addr, lk_write, mem_req_valid, mem_req_addr,
               fill_en, fill_way, resp_valid, resp_hit, hit_count, miss_count
    );

    modport master (
        output req_valid, req_addr0, req_addr1, req_write0, req_write1,
               lk_done, lk_hit, lk_way, mem_req_ready, mem_resp_valid,
        input  req_ready, lk_valid, lk_addr, lk_write, mem_req_valid, mem_req_addr,
               fill_en, fill_way, resp_valid, resp_hit, hit_count, miss_count
    );
endinterface

// File: rtl/cache_access_ctrl.sv
// Round-robin two-port front-end for the LRU cache: one lookup per request,
// block refill on a miss, one response per request, saturating hit/miss counters.
module cache_access_ctrl #(
    parameter int ADDR_W      = 24,
    parameter int OFFSET_BITS = 3,
    parameter int WAYS        = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_access_ctrl_if.slave bus
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT,
        FILL,
        RESP
    } state_t;

    state_t            state;
    logic              rr_ptr;
    logic              owner;
    logic              grant;
    logic              accept;
    logic [1:0]        ready;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [WAY_W-1:0]  victim;
    logic              lk_valid_q;
    logic              mem_req_valid_q;
    logic              fill_en_q;
    logic [1:0]        resp_valid_q;
    logic              resp_hit_q;
    logic [CNT_W-1:0]  hit_q;
    logic [CNT_W-1:0]  miss_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant = (bus.req_valid == 2'b11) ? rr_ptr : bus.req_valid[1];
        ready = 2'b00;
        if (rst_n && (state == IDLE) && (bus.req_valid != 2'b00)) begin
            ready[grant] = 1'b1;
        end
    end

    assign accept = |(ready & bus.req_valid);

    // NOTE: all state and registered outputs use non-blocking assignments so each flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_ptr          <= 1'b0;
            owner           <= 1'b0;
            addr_q          <= '0;
            write_q         <= 1'b0;
            victim          <= '0;
            lk_valid_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            fill_en_q       <= 1'b0;
            resp_valid_q    <= 2'b00;
            resp_hit_q      <= 1'b0;
            hit_q           <= '0;
            miss_q          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= grant ? bus.req_addr1 : bus.req_addr0;
                        write_q    <= grant ? bus.req_write1 : bus.req_write0;
                        owner      <= grant;
                        rr_ptr     <= ~grant;
                        lk_valid_q <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (bus.lk_done) begin
                        lk_valid_q <= 1'b0;
                        if (bus.lk_hit) begin
                            hit_q        <= sat_inc(hit_q);
                            resp_valid_q <= owner ? 2'b10 : 2'b01;
                            resp_hit_q   <= 1'b1;
                            state        <= RESP;
                        end else begin
                            // Write misses allocate too: same refill path as reads.
                            miss_q          <= sat_inc(miss_q);
                            victim          <= bus.lk_way;
                            mem_req_valid_q <= 1'b1;
                            state           <= REFILL_REQ;
                        end
                    end
                end
                REFILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        fill_en_q <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    fill_en_q    <= 1'b0;
                    resp_valid_q <= owner ? 2'b10 : 2'b01;
                    resp_hit_q   <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 2'b00;
                    resp_hit_q   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = ready;
    assign bus.lk_valid      = lk_valid_q;
    assign bus.lk_addr       = addr_q;
    assign bus.lk_write      = write_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = {addr_q[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign bus.fill_en       = fill_en_q;
    assign bus.fill_way      = victim;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.hit_count     = hit_q;
    assign bus.miss_count    = miss_q;
endmodule

// File: tb/tb_cache_access_ctrl.sv
// Self-checking bench for cache_access_ctrl: vector table, reactive cache/memory
// model, and a response scoreboard; built with CNT_W=4 to reach saturation.
module tb_cache_access_ctrl;
    localparam int ADDR_W      = 24;
    localparam int OFFSET_BITS = 3;
    localparam int WAYS        = 4;
    localparam int CNT_W       = 4;
    localparam int WAY_W       = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        int                port;
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic              hit;
        logic [WAY_W-1:0]  way;
        int                delay;
        logic [1:0]        exp_resp;
        logic              exp_hit;
        logic [ADDR_W-1:0] exp_mem_addr;
        int                exp_lat;
    } vec_t;

    typedef struct {
        logic [1:0]        exp_resp;
        logic              exp_hit;
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [ADDR_W-1:0] exp_mem_addr;
        logic [WAY_W-1:0]  way;
        int                t_acc;
        int                exp_lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_access_ctrl_if #(.ADDR_W(ADDR_W), .WAYS(WAYS), .CNT_W(CNT_W)) bus ();

    cache_access_ctrl #(
        .ADDR_W(ADDR_W), .OFFSET_BITS(OFFSET_BITS), .WAYS(WAYS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_hits = 0;
    int m_misses = 0;
    int fill_cnt = 0;
    int resp_cnt0 = 0;
    int resp_cnt1 = 0;
    sb_t sb[$];

    // Cache array / memory model knobs and stray-pulse injectors.
    logic             cfg_hit = 1'b1;
    logic [WAY_W-1:0] cfg_way = '0;
    int               cfg_delay = 0;
    logic             cfg_hold = 1'b0;
    logic r_lk_done = 1'b0, r_mem_ready = 1'b0, r_mem_resp = 1'b0, mem_pending = 1'b0;
    int   mem_wait = 0;
    logic stray_lk = 1'b0, stray_mem_resp = 1'b0, stray_mem_ready = 1'b0;

    assign bus.lk_done        = r_lk_done | stray_lk;
    assign bus.lk_hit         = cfg_hit;
    assign bus.lk_way         = cfg_way;
    assign bus.mem_req_ready  = r_mem_ready | stray_mem_ready;
    assign bus.mem_resp_valid = r_mem_resp | stray_mem_resp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Zero-wait lookup; memory accepts after cfg_delay cycles and returns data one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            r_lk_done = 1'b0; r_mem_ready = 1'b0; r_mem_resp = 1'b0;
            mem_pending = 1'b0; mem_wait = 0;
        end else begin
            r_lk_done  = bus.lk_valid;
            r_mem_resp = mem_pending && !cfg_hold;
            if (r_mem_resp) mem_pending = 1'b0;
            if (bus.mem_req_valid) begin
                r_mem_ready = (mem_wait >= cfg_delay);
                if (r_mem_ready) mem_pending = 1'b1;
                mem_wait++;
            end else begin
                r_mem_ready = 1'b0;
                mem_wait    = 0;
            end
        end
    end

    // Monitor: compares lookup, refill, fill and response activity against the scoreboard head.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            fill_cnt = 0;
        end else begin
            if (bus.fill_en) begin
                fill_cnt++;
                check("fill_expected", 32'(sb.size() != 0 && !sb[0].exp_hit), 32'd1);
                if (sb.size() != 0) begin
                    check("fill_way", 32'(bus.fill_way), 32'(sb[0].way));
                    check("fill_cycle", 32'(cyc - sb[0].t_acc), 32'(sb[0].exp_lat - 1));
                end
            end
            if (bus.lk_valid) begin
                check("lk_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    check("lk_addr", 32'(bus.lk_addr), 32'(sb[0].addr));
                    check("lk_write", 32'(bus.lk_write), 32'(sb[0].write));
                end
            end
            if (bus.mem_req_valid) begin
                check("mem_expected", 32'(sb.size() != 0 && !sb[0].exp_hit), 32'd1);
                if (sb.size() != 0)
                    check("mem_req_addr", 32'(bus.mem_req_addr), 32'(sb[0].exp_mem_addr));
            end
            if (bus.resp_valid != 2'b00) begin
                check("resp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_valid", 32'(bus.resp_valid), 32'(e.exp_resp));
                    check("resp_hit", 32'(bus.resp_hit), 32'(e.exp_hit));
                    check("resp_latency", 32'(cyc - e.t_acc), 32'(e.exp_lat));
                    if (!e.exp_hit) check("fill_count", 32'(fill_cnt), 32'd1);
                    if (bus.resp_valid[0]) resp_cnt0++;
                    if (bus.resp_valid[1]) resp_cnt1++;
                end
                fill_cnt = 0;
            end
        end
    end

    task automatic push_exp(input int port, input logic [ADDR_W-1:0] addr, input logic write,
                            input logic hit, input logic [WAY_W-1:0] way,
                            input logic [ADDR_W-1:0] mem_addr, input int lat);
        sb_t e;
        e.exp_resp     = (port == 0) ? 2'b01 : 2'b10;
        e.exp_hit      = hit;
        e.addr         = addr;
        e.write        = write;
        e.exp_mem_addr = mem_addr;
        e.way          = way;
        e.t_acc        = cyc;
        e.exp_lat      = lat;
        sb.push_back(e);
        if (hit) m_hits = sat(m_hits);
        else     m_misses = sat(m_misses);
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk); #2;
            guard++;
        end
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Drives one request; with both=1 the other port is also valid and v.port must still win.
    task automatic do_req(input vec_t v, input logic both);
        int guard = 0;
        cfg_hit = v.hit; cfg_way = v.way; cfg_delay = v.delay;
        @(negedge clk);
        if (v.port == 0) begin bus.req_addr0 = v.addr; bus.req_write0 = v.write; end
        else             begin bus.req_addr1 = v.addr; bus.req_write1 = v.write; end
        bus.req_valid = both ? 2'b11 : ((v.port == 0) ? 2'b01 : 2'b10);
        #1;
        while (bus.req_ready == 2'b00 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        check("accept_timeout", 32'(guard < 20), 32'd1);
        check("req_ready", 32'(bus.req_ready), 32'(v.exp_resp));
        if (guard < 20) begin
            push_exp(v.port, v.addr, v.write, v.hit, v.way, v.exp_mem_addr, v.exp_lat);
            @(posedge clk); #1;
            bus.req_valid = 2'b00;
            wait_drain("resp_timeout");
            check("hit_count", 32'(bus.hit_count), 32'(m_hits));
            check("miss_count", 32'(bus.miss_count), 32'(m_misses));
        end else begin
            bus.req_valid = 2'b00;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_lk_valid"}, 32'(bus.lk_valid), 32'd0);
        check({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, "_mem_req_addr"}, 32'(bus.mem_req_addr), 32'd0);
        check({tag, "_fill_en"}, 32'(bus.fill_en), 32'd0);
        check({tag, "_fill_way"}, 32'(bus.fill_way), 32'd0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_hit"}, 32'(bus.resp_hit), 32'd0);
        check({tag, "_hit_count"}, 32'(bus.hit_count), 32'd0);
        check({tag, "_miss_count"}, 32'(bus.miss_count), 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        cfg_hold = 1'b0;
        sb.delete();
        m_hits = 0; m_misses = 0; resp_cnt0 = 0; resp_cnt1 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   guard;
        int   exp_g;
        logic saw_req;

        tbl[0] = '{0, 24'h000040, 1'b0, 1'b1, 2'd1, 0, 2'b01, 1'b1, 24'h000040, 2};
        tbl[1] = '{1, 24'h12345F, 1'b1, 1'b0, 2'd2, 3, 2'b10, 1'b0, 24'h123458, 8};
        tbl[2] = '{1, 24'h00ABC3, 1'b0, 1'b1, 2'd3, 0, 2'b10, 1'b1, 24'h00ABC0, 2};
        tbl[3] = '{0, 24'h7FFFF9, 1'b1, 1'b1, 2'd0, 0, 2'b01, 1'b1, 24'h7FFFF8, 2};
        tbl[4] = '{0, 24'hFFFFFF, 1'b0, 1'b0, 2'd3, 0, 2'b01, 1'b0, 24'hFFFFF8, 5};
        tbl[5] = '{1, 24'h000007, 1'b1, 1'b0, 2'd0, 1, 2'b10, 1'b0, 24'h000000, 6};

        bus.req_valid = 2'b11;
        bus.req_addr0 = 24'h000111; bus.req_addr1 = 24'h000222;
        bus.req_write0 = 1'b0; bus.req_write1 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        bus.req_valid = 2'b00;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_req(tbl[i], 1'b0);

        // Stray lookup/memory pulses while idle.
        cfg_hit = 1'b1;
        @(negedge clk);
        stray_lk = 1'b1; stray_mem_resp = 1'b1; stray_mem_ready = 1'b1;
        @(negedge clk);
        stray_lk = 1'b0; stray_mem_resp = 1'b0; stray_mem_ready = 1'b0;
        repeat (2) begin
            check("stray_lk_valid", 32'(bus.lk_valid), 32'd0);
            check("stray_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
            check("stray_fill_en", 32'(bus.fill_en), 32'd0);
            check("stray_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("stray_hit_count", 32'(bus.hit_count), 32'(m_hits));
            check("stray_miss_count", 32'(bus.miss_count), 32'(m_misses));
            @(negedge clk);
        end

        // Stray refill data while the refill request is still waiting for ready.
        v = '{0, 24'h0456AB, 1'b0, 1'b0, 2'd1, 4, 2'b01, 1'b0, 24'h0456A8, 9};
        fork
            do_req(v, 1'b0);
            begin
                guard = 0;
                do begin @(negedge clk); guard++; end
                while (!bus.mem_req_valid && guard < 20);
                #1 stray_mem_resp = 1'b1;
                @(negedge clk);
                stray_mem_resp = 1'b0;
            end
        join

        // Both ports held valid: strict 0,1,0,1 alternation after reset.
        reset_dut();
        cfg_hit = 1'b1; cfg_way = 2'd1;
        bus.req_addr0 = 24'h000100; bus.req_write0 = 1'b0;
        bus.req_addr1 = 24'h000208; bus.req_write1 = 1'b1;
        @(negedge clk);
        bus.req_valid = 2'b11;
        exp_g = 0;
        for (int n = 0; n < 6; n++) begin
            guard = 0;
            #1;
            while (bus.req_ready == 2'b00 && guard < 20) begin
                @(negedge clk); #1;
                guard++;
            end
            check("b2b_grant", 32'(bus.req_ready), (exp_g == 0) ? 32'd1 : 32'd2);
            if (bus.req_ready[1])
                push_exp(1, bus.req_addr1, bus.req_write1, 1'b1, 2'd1, 24'h000208, 2);
            else
                push_exp(0, bus.req_addr0, bus.req_write0, 1'b1, 2'd1, 24'h000100, 2);
            @(posedge clk); #1;
            if (n == 5) bus.req_valid = 2'b00;
            @(negedge clk);
            exp_g ^= 1;
        end
        wait_drain("b2b_drain");
        check("b2b_hit_count", 32'(bus.hit_count), 32'd6);
        check("b2b_port0_resps", 32'(resp_cnt0), 32'd3);
        check("b2b_port1_resps", 32'(resp_cnt1), 32'd3);

        // Reset while waiting for refill data: abandoned, then port 0 favoured again.
        reset_dut();
        cfg_hold = 1'b1; cfg_hit = 1'b0; cfg_way = 2'd3; cfg_delay = 0;
        @(negedge clk);
        bus.req_addr0 = 24'h0ABCDE; bus.req_write0 = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        check("abort_accept", 32'(bus.req_ready), 32'd1);
        push_exp(0, 24'h0ABCDE, 1'b0, 1'b0, 2'd3, 24'h0ABCD8, 99);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        guard = 0; saw_req = 1'b0;
        do begin
            @(negedge clk);
            if (bus.mem_req_valid) saw_req = 1'b1;
            guard++;
        end while (!(saw_req && !bus.mem_req_valid) && guard < 20);
        check("abort_reach_wait", 32'(guard < 20), 32'd1);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check_reset_outputs("abort");
        sb.delete();
        m_hits = 0; m_misses = 0;
        repeat (2) @(negedge clk);
        check("abort_ready_in_reset", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 2'b00;
        cfg_hold = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
            check("abort_no_fill", 32'(bus.fill_en), 32'd0);
        end
        v = '{0, 24'h000300, 1'b0, 1'b1, 2'd2, 0, 2'b01, 1'b1, 24'h000300, 2};
        do_req(v, 1'b1);

        // Miss counter saturation in the 4-bit build.
        reset_dut();
        for (int n = 0; n < 14; n++) begin
            v = '{n % 2, 24'(24'h010000 + n * 8), 1'b0, 1'b0, 2'(n), 0,
                  (n % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 24'(24'h010000 + n * 8), 5};
            do_req(v, 1'b0);
        end
        check("miss_pre_sat", 32'(bus.miss_count), 32'hE);
        for (int n = 0; n < 3; n++) begin
            v = '{0, 24'h020005, 1'b1, 1'b0, 2'd1, 0, 2'b01, 1'b0, 24'h020000, 5};
            do_req(v, 1'b0);
            check("miss_saturated", 32'(bus.miss_count), 32'hF);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_access_ctrl.md
# cache_access_ctrl

Sequencing and arbitration front-end for the set-associative LRU cache. It accepts read/write requests from two requesters (port 0 instruction fetch, port 1 data) and grants them round-robin. It drives one tag lookup per request into the cache array and, on a miss, runs the block refill handshake with memory before committing the fill. It returns one response per request and keeps hit/miss statistics.

## Interface
- ADDR_W, 24, request address width
- OFFSET_BITS, 3, block-offset bits; cleared in refill address
- WAYS, 4, cache associativity; WAY_W = clog2(WAYS)
- CNT_W, 32, statistics counter width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, bit i = port i
- req_ready  out  2  request accepted when valid&ready on same bit
- req_addr0, req_addr1  in  ADDR_W  request address per port
- req_write0, req_write1  in  1  1 = write, 0 = read
- lk_valid  out  1  lookup request to cache array
- lk_addr  out  ADDR_W  captured request address
- lk_write  out  1  captured write flag
- lk_done  in  1  lookup result valid
- lk_hit  in  1  1 = hit
- lk_way  in  WAY_W  hit way on hit; LRU victim way on miss
- mem_req_valid  out  1  refill request
- mem_req_ready  in  1  memory accepts refill request
- mem_req_addr  out  ADDR_W  block-aligned refill address
- mem_resp_valid  in  1  refill data returned
- fill_en  out  1  one-cycle pulse: write tag, set valid, update LRU
- fill_way  out  WAY_W  way written by fill
- resp_valid  out  2  one-cycle response pulse to owning port
- resp_hit  out  1  1 = request was a hit
- hit_count, miss_count  out  CNT_W  statistics

## Operation
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, FILL, RESP.
- IDLE: grant g = requesting port; if both valid, g = rr pointer. req_ready[g] = 1 combinationally, other bit 0. On handshake: capture addr, write, owner = g; rr pointer <= ~g; -> LOOKUP. req_ready = 0 in all other states.
- LOOKUP: lk_valid = 1 with lk_addr/lk_write held. On lk_done: lk_hit=1 -> hit_count++, -> RESP; lk_hit=0 -> miss_count++, victim <= lk_way, -> REFILL_REQ.
- REFILL_REQ: mem_req_valid = 1, mem_req_addr = addr with [OFFSET_BITS-1:0] zeroed, held stable until mem_req_ready; then -> REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid -> FILL. mem_resp_valid is ignored in any other state.
- FILL: fill_en = 1, fill_way = victim, for exactly one cycle; -> RESP.
- RESP: resp_valid[owner] = 1, resp_hit = 1 if path was hit; -> IDLE.
- Writes are write-allocate: a write miss refills exactly like a read miss.
- Counters saturate at all-ones, never wrap.
- Only one request is in flight; no pipelining.

## Timing
- Reset (async, rst_n low): state IDLE, rr pointer = 0 (port 0 favoured), req_ready = 0 while in reset, lk_valid = mem_req_valid = fill_en = 0, resp_valid = 0, resp_hit = 0, fill_way = 0, mem_req_addr = 0, counters = 0. Reset mid-transaction abandons it with no response and no fill.
- All outputs except req_ready are registered or decoded from registered state.
- Hit latency: accept at cycle T, LOOKUP from T+1; lk_done at T+1 gives resp_valid at T+2, next accept at T+3.
- Miss latency with zero-wait memory (ready at T+2, resp at T+3): FILL T+4, RESP T+5.
- lk_done ignored outside LOOKUP; mem_req_ready ignored outside REFILL_REQ.
- Back-to-back: both ports held valid alternate 0,1,0,1 starting with port 0 after reset.

## Test plan
- Single read port 0, addr 0x000040, lk_done+lk_hit at T+1 -> resp_valid=2'b01, resp_hit=1 at T+2; hit_count=1, no mem_req_valid.
- Write port 1, addr 0x12345F, lk_hit=0 lk_way=2 -> mem_req_addr=0x123458; mem_req_ready delayed 3 cycles keeps addr stable; mem_resp_valid -> fill_en one cycle with fill_way=2, then resp_valid=2'b10, resp_hit=0, miss_count=1.
- Both ports valid continuously for 6 requests, all hits -> grant order 0,1,0,1,0,1; each port gets 3 responses, hit_count=6.
- Stray mem_resp_valid pulses in IDLE and REFILL_REQ, stray lk_done in IDLE -> no state change, no fill, counters unchanged.
- rst_n low during REFILL_WAIT -> all outputs at reset values immediately; after release, no resp_valid for the abandoned request and the next request is serviced normally from port 0.
- Force miss_count to all-ones minus 1 (CNT_W=4 build), issue 3 misses -> saturates at 4'hF.
